// File: rtl/booth_sequencer.sv
// Sequential radix-2 Booth signed multiplier. The iteration count is loaded
// on start and stepped down once per Booth step; each step is one add/sub cycle
// followed by one shift cycle.
module booth_sequencer #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        SHIFT,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [N:0]      a_q, a_d;
    logic [N:0]      mx_q, mx_d;
    logic [N-1:0]    q_q, q_d;
    logic            q1_q, q1_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]  product_q, product_d;
    logic [2*N+1:0]  shifted;

    // A carries one guard bit so that subtracting the most negative
    // multiplicand cannot overflow the accumulator.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        mx_d      = mx_q;
        q_d       = q_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        shifted   = {a_q[N], a_q, q_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    mx_d    = {multiplicand[N-1], multiplicand};
                    q_d     = multiplier;
                    a_d     = '0;
                    q1_d    = 1'b0;
                    cnt_d   = CW'(N);
                    state_d = EVAL;
                end
            end
            EVAL: begin
                case ({q_q[0], q1_q})
                    2'b01:   a_d = a_q + mx_q;
                    2'b10:   a_d = a_q - mx_q;
                    default: a_d = a_q;
                endcase
                state_d = SHIFT;
            end
            SHIFT: begin
                a_d   = shifted[2*N+1:N+1];
                q_d   = shifted[N:1];
                q1_d  = shifted[0];
                cnt_d = cnt_q - 1'b1;
                // The product is captured on the final shift so it is already
                // valid during the cycle where done is high.
                if (cnt_q == CW'(1)) begin
                    product_d = shifted[2*N:1];
                    state_d   = DONE;
                end else begin
                    state_d = EVAL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            mx_q      <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            mx_q      <= mx_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule

// File: tb/tb_booth_sequencer.sv
// Self-checking bench for booth_sequencer: directed cases, random operands
// against an integer-arithmetic reference, plus protocol checks.
module tb_booth_sequencer;

    localparam int N = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [N-1:0]     multiplicand;
    logic [N-1:0]     multiplier;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;

    int testsRun;
    int failCount;

    booth_sequencer #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [2*N-1:0] modelProduct(input logic [N-1:0] m, input logic [N-1:0] q);
        int mi;
        int qi;
        mi = int'($signed(m));
        qi = int'($signed(q));
        return (2*N)'(mi * qi);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation from IDLE: checks capture, busy span, latency, result.
    task automatic applyStimulus(input logic [N-1:0] m, input logic [N-1:0] q, input string tag);
        int edges;
        int busyCount;
        logic [2*N-1:0] expected;
        expected     = modelProduct(m, q);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        tick();
        start        = 1'b0;
        multiplicand = N'($urandom);
        multiplier   = N'($urandom);
        busyCount    = busy ? 1 : 0;
        edges        = 0;
        while (!done && edges < 4*N) begin
            tick();
            edges++;
            if (busy) busyCount++;
        end
        checkOutput({tag, "_latency"}, 64'(edges), 64'(2*N));
        checkOutput({tag, "_busy"}, 64'(busyCount), 64'(2*N+1));
        checkOutput({tag, "_product"}, 64'(product), 64'(expected));
        tick();
        checkOutput({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
        checkOutput({tag, "_hold"}, 64'(product), 64'(expected));
    endtask

    initial begin
        int doneCount;
        int busyLow;
        int lastDone;
        testsRun     = 0;
        failCount    = 0;
        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_state", {54'd0, busy, done, product}, 64'd0);

        applyStimulus(4'd3, 4'd2, "m3q2");
        applyStimulus(4'hD, 4'd5, "mneg3q5");
        applyStimulus(4'd7, 4'h8, "m7qneg8");
        applyStimulus(4'h8, 4'h8, "mneg8qneg8");
        applyStimulus(4'd0, 4'hF, "m0qneg1");
        applyStimulus(4'hF, 4'hF, "mneg1qneg1");
        applyStimulus(4'h8, 4'd7, "mneg8q7");

        // start pulses while busy, including during the done cycle, are ignored
        start = 1'b1; multiplicand = 4'd3; multiplier = 4'd3;
        tick();
        doneCount = 0;
        for (int e = 1; e <= 2*N+3; e++) begin
            start        = (e == 2 || e == 2*N || e == 2*N+1);
            multiplicand = 4'd5;
            multiplier   = 4'd5;
            tick();
            if (done) begin
                doneCount++;
                checkOutput("ignore_product", 64'(product), 64'h09);
            end
        end
        start = 1'b0;
        checkOutput("ignore_single_done", 64'(doneCount), 64'd1);
        checkOutput("ignore_no_restart", {63'd0, busy}, 64'd0);

        // reset in the middle of an operation aborts it silently
        start = 1'b1; multiplicand = 4'd6; multiplier = 4'h9;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 3; e++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_state", {54'd0, busy, done, product}, 64'd0);
        doneCount = 0;
        for (int e = 0; e < 3*N; e++) begin
            tick();
            if (done || busy) doneCount++;
        end
        checkOutput("abort_quiet", 64'(doneCount), 64'd0);
        applyStimulus(4'd6, 4'h9, "after_abort");

        // start held high: re-accepted in the first idle cycle after each completion
        start = 1'b1; multiplicand = 4'd2; multiplier = 4'hD;
        doneCount = 0;
        busyLow   = 0;
        lastDone  = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) begin
                doneCount++;
                checkOutput("b2b_product", 64'(product), 64'(modelProduct(4'd2, 4'hD)));
                if (lastDone >= 0) checkOutput("b2b_spacing", 64'(i - lastDone), 64'(2*N+2));
                lastDone = i;
            end
            if (!busy) begin
                busyLow++;
                checkOutput("b2b_gap", 64'(i), 64'(lastDone + 1));
            end
        end
        start = 1'b0;
        checkOutput("b2b_done_count", 64'(doneCount), 64'd3);
        checkOutput("b2b_idle_count", 64'(busyLow), 64'd3);
        tick();
        checkOutput("b2b_stopped", {63'd0, busy}, 64'd0);

        for (int t = 0; t < 40; t++) begin
            applyStimulus(N'($urandom), N'($urandom), "random");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
